// File: rtl/add_round_key_stage.sv
// Registered AddRoundKey stage of the iterative AES-128 encrypt datapath.
// The stage sits downstream of the combinational MixColumns block. It selects
// the MixColumns result, or the ShiftRows state for round 0 and the final
// round. It XORs that value with the round key held in an internal store and
// presents the result through a 2-entry output buffer.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. A producer holds valid and payload stable until the
// transfer. in_ready depends only on registered state, never on in_valid or
// out_ready. The output payload holds while out_valid && !out_ready, and it
// also holds its last value while the buffer is empty.
module add_round_key_stage #(
    parameter int NR    = 10,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_wr_en,
    input  logic [3:0]   key_wr_idx,
    input  logic [127:0] key_wr_data,
    input  logic         key_clear,
    output logic         key_loaded,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_mix,
    input  logic [127:0] in_shift,
    input  logic [3:0]   in_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [3:0]   out_round,
    output logic         out_last,
    output logic         err_round
);

    // Highest valid round index. Index comparisons are unsigned.
    localparam logic [3:0] LAST_IDX = 4'(NR);
    // Occupancy at which the buffer refuses new beats.
    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    typedef struct packed {
        logic [127:0] state;
        logic [3:0]   round;
        logic         last;
    } entry_t;

    // Round-key store and the per-key "written" mask.
    logic [127:0] key_mem [0:NR];
    logic [NR:0]  key_mask;
    logic         key_wr_hit;

    // Output buffer. The head register drives the outputs directly, so the
    // outputs keep their last value when the buffer empties.
    entry_t       head_q;
    entry_t       tail_q;
    logic [1:0]   count_q;

    // Datapath and handshake signals.
    logic         round_ok;
    logic         use_shift;
    logic [3:0]   key_sel;
    logic [127:0] operand;
    entry_t       new_entry;
    logic         accept;
    logic         push;
    logic         pop;

    // A write to an index above NR is dropped entirely.
    assign key_wr_hit = key_wr_en && (key_wr_idx <= LAST_IDX);

    // Round-key storage. The data is written even when key_clear is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) begin
                key_mem[i] <= '0;
            end
        end else if (key_wr_hit) begin
            key_mem[key_wr_idx] <= key_wr_data;
        end
    end

    // Loaded mask: key_clear wins over a write in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_mask <= '0;
        end else if (key_clear) begin
            key_mask <= '0;
        end else if (key_wr_hit) begin
            key_mask[key_wr_idx] <= 1'b1;
        end
    end

    assign key_loaded = &key_mask;

    // Handshake terms.
    assign in_ready  = key_loaded && (count_q < FULL_CNT);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && round_ok;
    assign pop       = out_valid && out_ready;

    // Operand select and XOR. The key read sees the pre-edge store contents,
    // so a beat accepted alongside a write to its key uses the old key.
    always_comb begin
        round_ok  = (in_round <= LAST_IDX);
        use_shift = (in_round == 4'd0) || (in_round == LAST_IDX);
        key_sel   = round_ok ? in_round : 4'd0;
        operand   = use_shift ? in_shift : in_mix;
        new_entry.state = operand ^ key_mem[key_sel];
        new_entry.round = in_round;
        new_entry.last  = (in_round == LAST_IDX);
    end

    // Buffer data movement. Push is impossible at count 2 because in_ready is
    // low, so a pop at count 2 only has to promote the tail entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (push && (count_q == 2'd0 || (count_q == 2'd1 && pop))) begin
                head_q <= new_entry;
            end else if (push && count_q == 2'd1) begin
                tail_q <= new_entry;
            end else if (pop && count_q == 2'd2) begin
                head_q <= tail_q;
            end
        end
    end

    // Buffer occupancy. A push and a pop in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // One-cycle error pulse for a consumed beat with an out-of-range round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_round <= 1'b0;
        end else begin
            err_round <= accept && !round_ok;
        end
    end

    assign out_state = head_q.state;
    assign out_round = head_q.round;
    assign out_last  = head_q.last;

endmodule
